// File: rtl/bcs_seq_ctrl_if.sv
// Requester and slice signals for bcs_seq_ctrl. The slave modport is the sequencer side,
// the master modport is the side that drives requests and hosts the comparator slice.
interface bcs_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic [8*NBYTES-1:0]   op_a;
  logic [8*NBYTES-1:0]   op_b;
  logic [7:0]            slice_a;
  logic [7:0]            slice_b;
  logic                  slice_eq;
  logic                  slice_gt;
  logic                  slice_EQ;
  logic                  slice_GT;
  logic                  busy;
  logic                  done;
  logic                  eq_out;
  logic                  gt_out;
  logic                  lt_out;

  modport master (
    output start, op_a, op_b, slice_EQ, slice_GT,
    input  slice_a, slice_b, slice_eq, slice_gt, busy, done, eq_out, gt_out, lt_out
  );

  modport slave (
    input  start, op_a, op_b, slice_EQ, slice_GT,
    output slice_a, slice_b, slice_eq, slice_gt, busy, done, eq_out, gt_out, lt_out
  );
endinterface

// File: rtl/bcs_seq_ctrl.sv
// Byte-serial wide unsigned compare through one external BCS8bit slice, MSB byte first.
// Defining BCS_SEQ_EARLY_EXIT_EN ends the sequence at the first differing byte.
module bcs_seq_ctrl #(
  parameter int NBYTES = 4,
  parameter int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bcs_seq_ctrl_if.slave io_bus
);
  // state   | meaning
  // IDLE    | waiting for start
  // COMPARE | one byte pair per cycle through the slice
  // DONE    | one-cycle done pulse, results registered on entry
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic [1:0]          r_state;
  logic [8*NBYTES-1:0] r_op_a;
  logic [8*NBYTES-1:0] r_op_b;
  logic [IW-1:0]       r_idx;
  logic                r_casc_eq;
  logic                r_casc_gt;
  logic                r_done;
  logic                r_eq;
  logic                r_gt;
  logic                r_lt;
  logic                w_last;
  logic [IW+2:0]       w_bit;

  assign w_bit = {r_idx, 3'b000};

`ifdef BCS_SEQ_EARLY_EXIT_EN
  // Once a byte differs the cascade eq is 0 and GT can no longer change.
  assign w_last = (r_idx == '0) || !io_bus.slice_EQ;
`else
  assign w_last = (r_idx == '0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_idx     <= IDX_LAST;
      r_casc_eq <= 1'b1;
      r_casc_gt <= 1'b0;
      r_done    <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_op_a    <= io_bus.op_a;
            r_op_b    <= io_bus.op_b;
            r_idx     <= IDX_LAST;
            r_casc_eq <= 1'b1;
            r_casc_gt <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_state   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_casc_eq <= io_bus.slice_EQ;
          r_casc_gt <= io_bus.slice_GT;
          if (w_last) begin
            // Results come straight from the slice so they appear with the done pulse.
            r_done  <= 1'b1;
            r_eq    <= io_bus.slice_EQ;
            r_gt    <= io_bus.slice_GT;
            r_lt    <= ~io_bus.slice_EQ & ~io_bus.slice_GT;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IDX_ONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.slice_a  = r_op_a[w_bit +: 8];
  assign io_bus.slice_b  = r_op_b[w_bit +: 8];
  assign io_bus.slice_eq = r_casc_eq;
  assign io_bus.slice_gt = r_casc_gt;
  assign io_bus.busy     = (r_state == S_COMPARE);
  assign io_bus.done     = r_done;
  assign io_bus.eq_out   = r_eq;
  assign io_bus.gt_out   = r_gt;
  assign io_bus.lt_out   = r_lt;
endmodule

// File: doc/bcs_seq_ctrl.md
Name: bcs_seq_ctrl

Overview:
- Multi-cycle sequencer that compares two wide unsigned operands using one shared 8-bit cascadable comparator slice (BCS8bit class).
- Feeds the slice one byte pair per cycle, MSB byte first, and registers the slice's EQ/GT outputs back as the next cycle's eq/gt cascade inputs.
- Sits between a requester (start/done handshake) and the external slice instance; the slice itself is not inside this block.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..16.
- IW, $clog2(NBYTES) (minimum 1), width of the internal byte index.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op_a  input  8*NBYTES  operand A, captured on accepted start
- op_b  input  8*NBYTES  operand B, captured on accepted start
- slice_a  output  8  byte of A presented to the slice
- slice_b  output  8  byte of B presented to the slice
- slice_eq  output  1  cascade eq into the slice
- slice_gt  output  1  cascade gt into the slice
- slice_EQ  input  1  slice result EQ
- slice_GT  input  1  slice result GT
- busy  output  1  high in COMPARE
- done  output  1  one-cycle pulse, result valid
- eq_out  output  1  A == B
- gt_out  output  1  A > B
- lt_out  output  1  A < B

Behaviour:
- Slice contract, combinational, unsigned: EQ = eq & (A==B); GT = gt | (eq & (A>B)).
- Reset (async, any state): state=IDLE; busy=0, done=0, eq_out=0, gt_out=0, lt_out=0; slice_a=slice_b=0, slice_eq=1, slice_gt=0; captured operands cleared.
- IDLE:
  - start=1 -> capture op_a/op_b, idx=NBYTES-1, cascade regs eq=1 gt=0, go to COMPARE.
  - start=0 -> stay.
- COMPARE:
  - slice_a / slice_b = captured byte[idx]; slice_eq / slice_gt = cascade regs (driven from registers).
  - On each edge: cascade regs <= slice_EQ / slice_GT.
  - idx==0 -> DONE; otherwise idx <= idx-1.
  - start is ignored.
- DONE (one cycle):
  - done=1; eq_out=cascade eq, gt_out=cascade gt, lt_out=~eq & ~gt; these are registered on DONE entry.
  - Next state IDLE. start is ignored in DONE.
- Results hold after done until the next accepted start; cleared to 0 on the COMPARE entry edge.
- Latency: start accepted on edge E -> done high during the cycle after edge E+NBYTES. Total start-to-done is NBYTES+1 cycles.
- Throughput: at most one comparison per NBYTES+2 cycles.
- NBYTES=1: a single COMPARE cycle, then DONE.
- Inconsistent slice response (EQ=1 and GT=1): gt_out follows GT, eq_out follows EQ, lt_out=0; no error flag.
- Reset mid-COMPARE: abort, no done pulse, outputs cleared.
- Operand inputs may change freely after the accepted start without affecting the result.

Optional Feature:
- Macro: BCS_SEQ_EARLY_EXIT_EN
- Defined: in COMPARE, if slice_EQ=0 is sampled on an edge, go to DONE immediately regardless of idx. Latency is k+1 cycles, where k = number of bytes compared up to and including the first differing byte. Results are identical to the full sequence.
- Undefined: all NBYTES bytes are always sequenced and latency is fixed at NBYTES+1.

Test Plan (NBYTES=4; bench instantiates a slice model meeting the contract):
- Equal operands: A=B=32'h2E2E2E2E, start pulse -> busy for 4 cycles, done 5 cycles after start, eq_out=1, gt_out=0, lt_out=0.
- MSB decides: A=32'h80000000, B=32'h7FFFFFFF -> gt_out=1, eq_out=0, lt_out=0. Slice sees bytes 80/7F first, then slice_eq=0 for the remaining bytes. With EARLY_EXIT_EN, done arrives 2 cycles after start.
- LSB decides: A=32'h0000002E, B=32'h0000002F -> lt_out=1; done 5 cycles after start in both builds.
- Start while busy: second start pulse 2 cycles into a compare of A=1, B=2 -> ignored; single done pulse, lt_out=1; next start accepted only after return to IDLE.
- Reset mid-COMPARE: assert rst 2 cycles after start -> immediate busy=0, no done, all result outputs 0; a fresh start then completes normally.
- Result hold: after a compare with A=5, B=3 (gt_out=1), change op_a/op_b with no start -> gt_out stays 1 until the next start, then clears on the COMPARE entry edge.
